// File: rtl/rs_ex_iter.sv
// rs_ex_iter: handshaked RV32IM execution unit behind the reservation station.
// 1-cycle ALU/branch/jump ops, fixed-latency multiply, iterative restoring divide.

package rs_ex_iter_pkg;
  localparam int unsigned OPENUM_LEN = 6;
  typedef logic [OPENUM_LEN-1:0] openum_t;

  localparam openum_t OPENUM_LUI    = 6'd1;
  localparam openum_t OPENUM_AUIPC  = 6'd2;
  localparam openum_t OPENUM_JAL    = 6'd3;
  localparam openum_t OPENUM_JALR   = 6'd4;
  localparam openum_t OPENUM_BEQ    = 6'd5;
  localparam openum_t OPENUM_BNE    = 6'd6;
  localparam openum_t OPENUM_BLT    = 6'd7;
  localparam openum_t OPENUM_BGE    = 6'd8;
  localparam openum_t OPENUM_BLTU   = 6'd9;
  localparam openum_t OPENUM_BGEU   = 6'd10;
  localparam openum_t OPENUM_ADDI   = 6'd11;
  localparam openum_t OPENUM_SLTI   = 6'd12;
  localparam openum_t OPENUM_SLTIU  = 6'd13;
  localparam openum_t OPENUM_XORI   = 6'd14;
  localparam openum_t OPENUM_ORI    = 6'd15;
  localparam openum_t OPENUM_ANDI   = 6'd16;
  localparam openum_t OPENUM_SLLI   = 6'd17;
  localparam openum_t OPENUM_SRLI   = 6'd18;
  localparam openum_t OPENUM_SRAI   = 6'd19;
  localparam openum_t OPENUM_ADD    = 6'd20;
  localparam openum_t OPENUM_SUB    = 6'd21;
  localparam openum_t OPENUM_SLL    = 6'd22;
  localparam openum_t OPENUM_SLT    = 6'd23;
  localparam openum_t OPENUM_SLTU   = 6'd24;
  localparam openum_t OPENUM_XOR    = 6'd25;
  localparam openum_t OPENUM_SRL    = 6'd26;
  localparam openum_t OPENUM_SRA    = 6'd27;
  localparam openum_t OPENUM_OR     = 6'd28;
  localparam openum_t OPENUM_AND    = 6'd29;
  localparam openum_t OPENUM_MUL    = 6'd30;
  localparam openum_t OPENUM_MULH   = 6'd31;
  localparam openum_t OPENUM_MULHSU = 6'd32;
  localparam openum_t OPENUM_MULHU  = 6'd33;
  localparam openum_t OPENUM_DIV    = 6'd34;
  localparam openum_t OPENUM_DIVU   = 6'd35;
  localparam openum_t OPENUM_REM    = 6'd36;
  localparam openum_t OPENUM_REMU   = 6'd37;
endpackage

module rs_ex_iter
  import rs_ex_iter_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned OP_W    = OPENUM_LEN,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_openum,
  input  logic [XLEN-1:0]   in_V1,
  input  logic [XLEN-1:0]   in_V2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [ADDR_W-1:0] out_target_pc,
  output logic              out_jump,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned SHW     = $clog2(XLEN);
  localparam int unsigned CNT_W   = $clog2(XLEN);
  localparam int unsigned MUL_END = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q;
  logic              qneg_q, rneg_q, drem_q;

  logic              accept;
  logic [XLEN-1:0]   op_b, alu_res;
  logic [ADDR_W-1:0] alu_tgt, br_tgt;
  logic              alu_jmp, is_mul, is_div, is_br, taken, lt_s, lt_u, is_imm;
  logic [SHW-1:0]    shamt;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic              div_signed, div_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     rem_sh, diff;
  logic [XLEN-1:0]   rem_n, quo_n, div_res;

  // Issue is blocked while an iterative op runs or an ungranted result is pending
  assign in_ready = rdy && !flush && (state_q != S_MUL) && (state_q != S_DIV)
                    && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath on issued operands; also multiply product and divide special cases
  always_comb begin
    alu_res    = '0;
    alu_tgt    = '0;
    alu_jmp    = 1'b0;
    is_mul     = 1'b0;
    is_div     = 1'b0;
    is_br      = 1'b0;
    taken      = 1'b0;
    is_imm     = in_openum inside {OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI,
                                   OPENUM_ORI, OPENUM_ANDI, OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI};
    op_b       = is_imm ? in_imm : in_V2;
    shamt      = op_b[SHW-1:0];
    lt_s       = $signed(in_V1) < $signed(op_b);
    lt_u       = in_V1 < op_b;
    br_tgt     = in_pc + ADDR_W'(in_imm);

    mul_a      = (in_openum == OPENUM_MULH || in_openum == OPENUM_MULHSU)
                 ? {{XLEN{in_V1[XLEN-1]}}, in_V1} : {{XLEN{1'b0}}, in_V1};
    mul_b      = (in_openum == OPENUM_MULH) ? {{XLEN{in_V2[XLEN-1]}}, in_V2} : {{XLEN{1'b0}}, in_V2};
    mul_p      = mul_a * mul_b;

    div_signed = (in_openum == OPENUM_DIV) || (in_openum == OPENUM_REM);
    div_rem    = (in_openum == OPENUM_REM) || (in_openum == OPENUM_REMU);
    a_neg      = div_signed && in_V1[XLEN-1];
    b_neg      = div_signed && in_V2[XLEN-1];
    a_mag      = a_neg ? -in_V1 : in_V1;
    b_mag      = b_neg ? -in_V2 : in_V2;
    div_zero   = (in_V2 == '0);
    div_ovf    = div_signed && (in_V1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_V2 == '1);

    case (in_openum)
      OPENUM_LUI:   alu_res = in_imm;
      OPENUM_AUIPC: alu_res = XLEN'(br_tgt);
      OPENUM_JAL: begin
        alu_res = XLEN'(in_pc + ADDR_W'(4));
        alu_tgt = br_tgt;
        alu_jmp = 1'b1;
      end
      OPENUM_JALR: begin
        alu_res = XLEN'(in_pc + ADDR_W'(4));
        alu_tgt = ADDR_W'(in_V1 + in_imm) & ~ADDR_W'(1);
        alu_jmp = 1'b1;
      end
      OPENUM_BEQ:  begin is_br = 1'b1; taken = (in_V1 == in_V2); end
      OPENUM_BNE:  begin is_br = 1'b1; taken = (in_V1 != in_V2); end
      OPENUM_BLT:  begin is_br = 1'b1; taken = lt_s;  end
      OPENUM_BGE:  begin is_br = 1'b1; taken = !lt_s; end
      OPENUM_BLTU: begin is_br = 1'b1; taken = lt_u;  end
      OPENUM_BGEU: begin is_br = 1'b1; taken = !lt_u; end
      OPENUM_ADDI, OPENUM_ADD: alu_res = in_V1 + op_b;
      OPENUM_SUB:              alu_res = in_V1 - op_b;
      OPENUM_SLTI, OPENUM_SLT:  alu_res = XLEN'(lt_s);
      OPENUM_SLTIU, OPENUM_SLTU: alu_res = XLEN'(lt_u);
      OPENUM_XORI, OPENUM_XOR: alu_res = in_V1 ^ op_b;
      OPENUM_ORI, OPENUM_OR:   alu_res = in_V1 | op_b;
      OPENUM_ANDI, OPENUM_AND: alu_res = in_V1 & op_b;
      OPENUM_SLLI, OPENUM_SLL: alu_res = in_V1 << shamt;
      OPENUM_SRLI, OPENUM_SRL: alu_res = in_V1 >> shamt;
      OPENUM_SRAI, OPENUM_SRA: alu_res = XLEN'($signed(in_V1) >>> shamt);
      OPENUM_MUL: begin
        is_mul  = 1'b1;
        alu_res = mul_p[XLEN-1:0];
      end
      OPENUM_MULH, OPENUM_MULHSU, OPENUM_MULHU: begin
        is_mul  = 1'b1;
        alu_res = mul_p[2*XLEN-1:XLEN];
      end
      OPENUM_DIV, OPENUM_DIVU, OPENUM_REM, OPENUM_REMU: begin
        is_div = 1'b1;
        // Fast-path results; only used when the divider is skipped
        if (div_zero)     alu_res = div_rem ? in_V1 : '1;
        else if (div_ovf) alu_res = div_rem ? '0 : in_V1;
      end
      default: alu_res = '0;
    endcase

    if (is_br) begin
      alu_res = XLEN'(taken);
      alu_jmp = taken;
      alu_tgt = br_tgt;
    end
  end

  // One restoring-divide step on magnitudes, with sign fixup folded into the last step
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvsr_q};
    rem_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], ~diff[XLEN]};
    div_res = drem_q ? (rneg_q ? -rem_n : rem_n) : (qneg_q ? -quo_n : quo_n);
  end

  // Control FSM, divider state and registered CDB outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      drem_q        <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_target_pc <= '0;
      out_jump      <= 1'b0;
      out_tag       <= '0;
    end else if (flush) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else if (rdy) begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state_q   <= S_IDLE;
      end

      case (state_q)
        S_MUL: begin
          if (cnt_q == CNT_W'(MUL_END)) begin
            cnt_q     <= '0;
            state_q   <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            cnt_q      <= '0;
            out_result <= div_res;
            state_q    <= S_DONE;
            out_valid  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase

      if (accept) begin
        out_tag       <= in_tag;
        out_result    <= alu_res;
        out_target_pc <= alu_tgt;
        out_jump      <= alu_jmp;
        cnt_q         <= '0;
        if (is_div && !div_zero && !div_ovf) begin
          state_q   <= S_DIV;
          out_valid <= 1'b0;
          rem_q     <= '0;
          quo_q     <= a_mag;
          dvsr_q    <= b_mag;
          qneg_q    <= a_neg ^ b_neg;
          rneg_q    <= a_neg;
          drem_q    <= div_rem;
        end else if (is_mul && (MUL_LAT > 1)) begin
          state_q   <= S_MUL;
          out_valid <= 1'b0;
        end else begin
          state_q   <= S_DONE;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
